// File: rtl/video_reader_pkg.sv
// Shared types and constants for the video frame reader.
package video_reader_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Bits needed to hold any count from 0 up to and including max_value.
  function automatic int cnt_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/video_frame_reader_fifo.sv
// Show-ahead pixel FIFO with a registered RAM read and a used-word count.
module video_frame_reader_fifo
  import video_reader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] used
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int USED_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  head_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_next;
  logic [USED_W-1:0] used_reg;
  logic              push;
  logic              pop;

  assign push        = wr_en && (used_reg != USED_W'(DEPTH));
  assign pop         = rd_en && (used_reg != '0);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // The head register prefetches the entry at the next read pointer; a write
  // landing on that very slot is forwarded so it is visible one cycle later.
  always_ff @(posedge clk) begin
    if (push && (wr_ptr_reg == rd_ptr_next)) head_reg <= wr_data;
    else                                     head_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      used_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({push, pop})
        2'b10:   used_reg <= used_reg + USED_W'(1);
        2'b01:   used_reg <= used_reg - USED_W'(1);
        default: used_reg <= used_reg;
      endcase
    end
  end

  assign rd_data = head_reg;
  assign valid   = (used_reg != '0);
  assign used    = used_reg;

endmodule

// File: rtl/video_frame_reader.sv
// Reads one frame of words over an Avalon pipelined master into a pixel stream.
// Define VIDEO_READER_UNDERFLOW_CNT_EN to build the stream-starvation counter.
module video_frame_reader
  import video_reader_pkg::*;
#(
  parameter int FRAME_WORDS = 76800,
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_PENDING = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic              master_waitrequest,
  input  logic [DATA_W-1:0] master_readdata,
  input  logic              master_readdatavalid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof,
  output logic [15:0]       underflow_cnt
);

  localparam int CNT_W  = cnt_width(FRAME_WORDS);
  localparam int PEND_W = cnt_width(MAX_PENDING);
  localparam int USED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_WORDS - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  issue_cnt_reg;
  logic [CNT_W-1:0]  pop_cnt_reg;
  logic [PEND_W-1:0] pending_reg;
  logic              done_reg;
  logic [USED_W-1:0] fifo_used;
  logic [31:0]       credit_sum;
  logic              accept;
  logic              push;
  logic              pop;

  // Counting in-flight reads against FIFO space means every returned word has
  // a slot reserved. The sum cannot grow while a request stalls, so a request
  // once raised stays raised until it is accepted.
  assign credit_sum  = 32'(pending_reg) + 32'(fifo_used);
  assign master_read = (state_reg == READ)
                    && (credit_sum < 32'(FIFO_DEPTH))
                    && (32'(pending_reg) < 32'(MAX_PENDING));
  assign master_address = addr_reg;
  assign accept = master_read && !master_waitrequest;
  assign push   = master_readdatavalid && (state_reg != IDLE);
  assign pop    = pix_valid && pix_ready;
  assign busy   = (state_reg != IDLE);
  assign done   = done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      issue_cnt_reg <= '0;
      pop_cnt_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= READ;
            addr_reg      <= base_addr;
            issue_cnt_reg <= '0;
            pop_cnt_reg   <= '0;
          end
        end
        READ: begin
          if (accept) begin
            addr_reg      <= addr_reg + ADDR_W'(1);
            issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
            if (issue_cnt_reg == LAST) state_reg <= DRAIN;
          end
          if (pop) pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
        end
        DRAIN: begin
          if (pop) begin
            pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
            if (pop_cnt_reg == LAST) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      case ({accept, push && (pending_reg != '0)})
        2'b10:   pending_reg <= pending_reg + PEND_W'(1);
        2'b01:   pending_reg <= pending_reg - PEND_W'(1);
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  video_frame_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (master_readdata),
    .rd_en   (pop),
    .rd_data (pix_data),
    .valid   (pix_valid),
    .used    (fifo_used)
  );

  assign pix_sof = pix_valid && busy && (pop_cnt_reg == '0);
  assign pix_eof = pix_valid && busy && (pop_cnt_reg == LAST);

`ifdef VIDEO_READER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_reg <= '0;
    end else if ((state_reg == IDLE) && start) begin
      underflow_reg <= '0;
    end else if (busy && pix_ready && !pix_valid && (underflow_reg != 16'hFFFF)) begin
      underflow_reg <= underflow_reg + 16'd1;
    end
  end

  assign underflow_cnt = underflow_reg;
`else
  assign underflow_cnt = '0;
`endif

endmodule
